// File: rtl/branch_ctrl.sv
// Multi-cycle branch resolution controller: evaluates one conditional
// branch at a time and computes its target. A taken, aligned branch issues
// a fetch redirect, which is followed by a one-cycle pipeline flush.
// Saturating statistics counters track branches evaluated and branches taken.
module branch_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [XLEN-1:0]  br_pc,
  input  logic [XLEN-1:0]  br_rs1_data,
  input  logic [XLEN-1:0]  br_rs2_data,
  input  logic [11:0]      br_imm,
  input  logic [2:0]       br_control,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             flush,
  output logic             misalign_err,
  output logic             busy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  // Condition codes follow the RISC-V funct3 encoding of the branch decoder
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT, FLUSH} state_t;

  state_t            state;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   rs2_q;
  logic [11:0]       imm_q;
  logic [2:0]        ctl_q;

  logic              taken;
  logic [XLEN-1:0]   target;
  logic [CNT_W-1:0]  cnt_max;

  assign br_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign cnt_max  = '1;

  // Condition evaluation and target computation from the captured branch
  always_comb begin
    taken  = (rs1_q == rs2_q);
    target = pc_q + {{(XLEN-13){imm_q[11]}}, imm_q, 1'b0};
    case (ctl_q)
      BR_BEQ:  taken = (rs1_q == rs2_q);
      BR_BNE:  taken = (rs1_q != rs2_q);
      BR_BLT:  taken = ($signed(rs1_q) <  $signed(rs2_q));
      BR_BGE:  taken = ($signed(rs1_q) >= $signed(rs2_q));
      BR_BLTU: taken = (rs1_q <  rs2_q);
      BR_BGEU: taken = (rs1_q >= rs2_q);
      default: taken = (rs1_q == rs2_q);
    endcase
  end

  // Control FSM with registered redirect, flush and misalignment outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc_q           <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      imm_q          <= '0;
      ctl_q          <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      misalign_err   <= 1'b0;
    end else begin
      flush        <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (br_valid) begin
            pc_q  <= br_pc;
            rs1_q <= br_rs1_data;
            rs2_q <= br_rs2_data;
            imm_q <= br_imm;
            ctl_q <= br_control;
            state <= EVAL;
          end
        end
        EVAL: begin
          if (!taken) begin
            state <= IDLE;
          end else if (target[1:0] != 2'b00) begin
            misalign_err <= 1'b1;
            state        <= IDLE;
          end else begin
            redirect_valid <= 1'b1;
            redirect_pc    <= target;
            state          <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            flush          <= 1'b1;
            state          <= FLUSH;
          end
        end
        FLUSH: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating statistics counters; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (state == EVAL) begin
      if (branch_cnt != cnt_max) branch_cnt <= branch_cnt + CNT_W'(1);
      if (taken && (taken_cnt != cnt_max)) taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule
